// File: rtl/parking_pkg.sv
// Shared gate state type and calendar constants for the parking gate controller.
package parking_pkg;

   localparam int HOURS_PER_DAY = 24;
   localparam int HOUR_W        = 8;
   localparam int DEFAULT_CNT_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      DENY,
      CLOSE
   } gate_state_t;

endpackage

// File: rtl/parking_gate_controller_if.sv
// Barrier-side signals: sensor/badge inputs towards the controller, actuator and event pulses back out.
interface parking_gate_controller_if;

   logic entry_req;
   logic entry_is_uni;
   logic entry_pass;
   logic exit_req;
   logic exit_is_uni;
   logic exit_pass;

   logic car_entered;
   logic is_uni_car_entered;
   logic car_exited;
   logic is_uni_car_exited;
   logic entry_gate_open;
   logic exit_gate_open;
   logic entry_denied;
   logic exit_denied;
   logic entry_timeout;
   logic exit_timeout;

   // master is the sensor side of the barriers, slave is the controller
   modport master (
      output entry_req, entry_is_uni, entry_pass,
      output exit_req, exit_is_uni, exit_pass,
      input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
      input  entry_gate_open, exit_gate_open, entry_denied, exit_denied,
      input  entry_timeout, exit_timeout
   );

   modport slave (
      input  entry_req, entry_is_uni, entry_pass,
      input  exit_req, exit_is_uni, exit_pass,
      output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
      output entry_gate_open, exit_gate_open, entry_denied, exit_denied,
      output entry_timeout, exit_timeout
   );

endinterface

// File: rtl/parking_gate_fsm.sv
// One barrier: accepts a badge request, opens or denies, then waits for the car or a timeout.
module parking_gate_fsm
   import parking_pkg::*;
#(
   parameter int OPEN_TIMEOUT = 8,
   parameter int CLOSE_HOLD   = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic is_uni,
   input  logic permit,
   input  logic pass,
   output logic gate_open,
   output logic event_pulse,
   output logic event_is_uni,
   output logic denied,
   output logic timeout
);

   localparam int TMR_W  = $clog2(OPEN_TIMEOUT + 1);
   localparam int HOLD_W = $clog2(CLOSE_HOLD + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLOSE_HOLD - 1);

   gate_state_t       state;
   logic [TMR_W-1:0]  open_tmr;
   logic [HOLD_W-1:0] hold_cnt;
   logic              latched_uni;

   // Pulses default low every cycle; pass is checked before the timer so a
   // car arriving on the last open cycle still counts as an event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         open_tmr     <= '0;
         hold_cnt     <= '0;
         latched_uni  <= 1'b0;
         gate_open    <= 1'b0;
         event_pulse  <= 1'b0;
         event_is_uni <= 1'b0;
         denied       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         event_pulse  <= 1'b0;
         event_is_uni <= 1'b0;
         denied       <= 1'b0;
         timeout      <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  latched_uni <= is_uni;
                  if (permit) begin
                     state     <= OPEN;
                     gate_open <= 1'b1;
                     open_tmr  <= '0;
                  end else begin
                     state  <= DENY;
                     denied <= 1'b1;
                  end
               end
            end
            DENY: begin
               state <= IDLE;
            end
            OPEN: begin
               if (pass) begin
                  state        <= CLOSE;
                  gate_open    <= 1'b0;
                  event_pulse  <= 1'b1;
                  event_is_uni <= latched_uni;
                  hold_cnt     <= '0;
               end else if (open_tmr == TMR_LAST) begin
                  state     <= CLOSE;
                  gate_open <= 1'b0;
                  timeout   <= 1'b1;
                  hold_cnt  <= '0;
               end else begin
                  open_tmr <= open_tmr + 1'b1;
               end
            end
            CLOSE: begin
               if (hold_cnt == HOLD_LAST) begin
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/parking_gate_controller.sv
// Event front end for parking_management: entry/exit gate FSMs, their permit muxes and the hour clock.
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter int CYCLES_PER_HOUR = 10,
   parameter int START_HOUR      = 0,
   parameter int OPEN_TIMEOUT    = 8,
   parameter int CLOSE_HOLD      = 2,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   parking_gate_controller_if.slave  gate_if,
   input  logic                      uni_is_vacated_space,
   input  logic                      is_vacated_space,
   input  logic [CNT_W-1:0]          uni_parked_car,
   input  logic [CNT_W-1:0]          parked_car,
   output logic [HOUR_W-1:0]         current_hour
);

   localparam int CYC_W = $clog2(CYCLES_PER_HOUR);
   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES_PER_HOUR - 1);
   localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_DAY - 1);
   localparam logic [HOUR_W-1:0] HOUR_INIT = HOUR_W'(START_HOUR);

   logic             entry_permit;
   logic             exit_permit;
   logic [CYC_W-1:0] cycle_cnt;

   // A car may only leave under a class that still has a car parked.
   assign entry_permit = gate_if.entry_is_uni ? uni_is_vacated_space : is_vacated_space;
   assign exit_permit  = gate_if.exit_is_uni ? (uni_parked_car != '0) : (parked_car != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt    <= '0;
         current_hour <= HOUR_INIT;
      end else if (cycle_cnt == CYC_LAST) begin
         cycle_cnt    <= '0;
         current_hour <= (current_hour == HOUR_LAST) ? '0 : current_hour + 1'b1;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   parking_gate_fsm #(
      .OPEN_TIMEOUT (OPEN_TIMEOUT),
      .CLOSE_HOLD   (CLOSE_HOLD)
   ) u_entry_fsm (
      .clk          (clk),
      .reset        (reset),
      .req          (gate_if.entry_req),
      .is_uni       (gate_if.entry_is_uni),
      .permit       (entry_permit),
      .pass         (gate_if.entry_pass),
      .gate_open    (gate_if.entry_gate_open),
      .event_pulse  (gate_if.car_entered),
      .event_is_uni (gate_if.is_uni_car_entered),
      .denied       (gate_if.entry_denied),
      .timeout      (gate_if.entry_timeout)
   );

   parking_gate_fsm #(
      .OPEN_TIMEOUT (OPEN_TIMEOUT),
      .CLOSE_HOLD   (CLOSE_HOLD)
   ) u_exit_fsm (
      .clk          (clk),
      .reset        (reset),
      .req          (gate_if.exit_req),
      .is_uni       (gate_if.exit_is_uni),
      .permit       (exit_permit),
      .pass         (gate_if.exit_pass),
      .gate_open    (gate_if.exit_gate_open),
      .event_pulse  (gate_if.car_exited),
      .event_is_uni (gate_if.is_uni_car_exited),
      .denied       (gate_if.exit_denied),
      .timeout      (gate_if.exit_timeout)
   );

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench: gate transactions queue their expected outcome, a negedge monitor matches DUT pulses.
module tb_parking_gate_controller;
   import parking_pkg::*;

   localparam int CPH     = 10;
   localparam int START_H = 0;
   localparam int T_OPEN  = 8;
   localparam int T_HOLD  = 2;
   localparam int CW      = 10;

   localparam int K_EVENT   = 1;
   localparam int K_DENY    = 2;
   localparam int K_TIMEOUT = 3;

   typedef struct {
      int   cyc;
      int   kind;
      logic cls;
      int   opened;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              uni_is_vacated_space = 1'b0;
   logic              is_vacated_space = 1'b0;
   logic [CW-1:0]     uni_parked_car = '0;
   logic [CW-1:0]     parked_car = '0;
   logic [HOUR_W-1:0] current_hour;

   int   cyc = 0;
   int   run_edges = 0;
   int   total = 0;
   int   bad = 0;
   logic last_edge_reset = 1'b1;
   logic started = 1'b0;
   logic done = 1'b0;
   logic final_checked = 1'b0;
   int   open_cnt [2] = '{0, 0};
   exp_t entry_q [$];
   exp_t exit_q [$];

   parking_gate_controller_if gif ();

   parking_gate_controller #(
      .CYCLES_PER_HOUR (CPH),
      .START_HOUR      (START_H),
      .OPEN_TIMEOUT    (T_OPEN),
      .CLOSE_HOLD      (T_HOLD),
      .CNT_W           (CW)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .gate_if              (gif),
      .uni_is_vacated_space (uni_is_vacated_space),
      .is_vacated_space     (is_vacated_space),
      .uni_parked_car       (uni_parked_car),
      .parked_car           (parked_car),
      .current_hour         (current_hour)
   );

   always #5 clk = ~clk;

   // run_edges counts clock edges since the last reset edge, which is all the hour model needs
   always @(posedge clk) begin
      cyc             <= cyc + 1;
      run_edges       <= reset ? 0 : run_edges + 1;
      last_edge_reset <= reset;
      started         <= 1'b1;
   end

   task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d at cycle %0d", name, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] want_bits(input int kind);
      case (kind)
         K_EVENT:   return 32'd4;
         K_DENY:    return 32'd2;
         K_TIMEOUT: return 32'd1;
         default:   return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input bit ex);
      logic  ev, cls, dn, to, go;
      exp_t  e;
      string nm;
      nm = ex ? "exit" : "entry";
      if (ex) begin
         ev = gif.car_exited;  cls = gif.is_uni_car_exited;
         dn = gif.exit_denied; to  = gif.exit_timeout; go = gif.exit_gate_open;
      end else begin
         ev = gif.car_entered;  cls = gif.is_uni_car_entered;
         dn = gif.entry_denied; to  = gif.entry_timeout; go = gif.entry_gate_open;
      end
      if (last_edge_reset) begin
         compare({nm, "_reset_outputs"}, {27'd0, go, ev, cls, dn, to}, 32'd0);
         open_cnt[ex] = 0;
         if (ex) exit_q.delete();
         else    entry_q.delete();
      end else if (ev | dn | to) begin
         if ((ex ? exit_q.size() : entry_q.size()) == 0) begin
            compare({nm, "_unexpected_pulse"}, {29'd0, ev, dn, to}, 32'd0);
         end else begin
            e = ex ? exit_q.pop_front() : entry_q.pop_front();
            compare({nm, "_pulse_cycle"}, cyc, e.cyc);
            compare({nm, "_pulse_kind"}, {29'd0, ev, dn, to}, want_bits(e.kind));
            compare({nm, "_class"}, {31'd0, cls}, (e.kind == K_EVENT) ? {31'd0, e.cls} : 32'd0);
            compare({nm, "_open_cycles"}, open_cnt[ex], e.opened);
            compare({nm, "_gate_closed"}, {31'd0, go}, 32'd0);
         end
         open_cnt[ex] = 0;
      end else begin
         compare({nm, "_class_idle"}, {31'd0, cls}, 32'd0);
         if (go) open_cnt[ex]++;
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         checkOutput(1'b0);
         checkOutput(1'b1);
         compare("current_hour", {24'd0, current_hour}, (START_H + run_edges / CPH) % HOURS_PER_DAY);
         if (done && !final_checked) begin
            compare("entry_queue_drained", entry_q.size(), 0);
            compare("exit_queue_drained", exit_q.size(), 0);
            final_checked = 1'b1;
         end
      end
   end

   task automatic drive(input bit ex, input logic req, input logic pass);
      if (ex) begin
         gif.exit_req    = req;
         gif.exit_pass   = pass;
         gif.exit_is_uni = 1'($urandom);
         uni_parked_car  = CW'($urandom);
         parked_car      = CW'($urandom);
      end else begin
         gif.entry_req        = req;
         gif.entry_pass       = pass;
         gif.entry_is_uni     = 1'($urandom);
         uni_is_vacated_space = 1'($urandom);
         is_vacated_space     = 1'($urandom);
      end
   endtask

   // One badge transaction on one gate; avail is spaces (entry, nonzero = yes) or parked cars (exit).
   // pass_at is the open cycle (1-based) with the car on the loop; beyond T_OPEN means no car.
   task automatic applyStimulus(input bit ex, input bit cls, input int avail, input int pass_at,
                                input int idle_n);
      int   k;
      exp_t e;
      bit   permit;
      permit = (avail != 0);
      repeat (idle_n) begin
         @(negedge clk);
         drive(ex, 1'b0, 1'($urandom));
      end
      @(negedge clk);
      k = cyc;
      drive(ex, 1'b1, 1'($urandom));
      if (ex) begin
         gif.exit_is_uni = cls;
         if (cls) uni_parked_car = CW'(avail);
         else     parked_car     = CW'(avail);
      end else begin
         gif.entry_is_uni = cls;
         if (cls) uni_is_vacated_space = permit;
         else     is_vacated_space     = permit;
      end
      if (!permit)
         e = '{cyc: k + 1, kind: K_DENY, cls: 1'b0, opened: 0};
      else if (pass_at >= 1 && pass_at <= T_OPEN)
         e = '{cyc: k + pass_at + 1, kind: K_EVENT, cls: cls, opened: pass_at};
      else
         e = '{cyc: k + T_OPEN + 1, kind: K_TIMEOUT, cls: 1'b0, opened: T_OPEN};
      if (ex) exit_q.push_back(e);
      else    entry_q.push_back(e);
      if (permit) begin
         for (int j = 1; j < e.cyc - k; j++) begin
            @(negedge clk);
            drive(ex, 1'($urandom), (j == pass_at));
         end
      end
      repeat (permit ? T_HOLD : 1) begin
         @(negedge clk);
         drive(ex, 1'($urandom), 1'($urandom));
      end
      @(negedge clk);
      drive(ex, 1'b0, 1'b0);
   endtask

   initial begin
      gif.entry_req    = 1'b0;
      gif.entry_is_uni = 1'b0;
      gif.entry_pass   = 1'b0;
      gif.exit_req     = 1'b0;
      gif.exit_is_uni  = 1'b0;
      gif.exit_pass    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      $display("[TB] directed gate transactions");
      applyStimulus(1'b0, 1'b1, 1, 3, 1);
      applyStimulus(1'b0, 1'b0, 0, 3, 0);
      applyStimulus(1'b1, 1'b0, 3, 99, 0);
      applyStimulus(1'b1, 1'b0, 0, 1, 0);
      fork
         applyStimulus(1'b0, 1'b1, 1, 2, 0);
         applyStimulus(1'b1, 1'b0, 5, 2, 0);
      join
      applyStimulus(1'b0, 1'b0, 1, T_OPEN, 0);
      applyStimulus(1'b1, 1'b1, 7, T_OPEN, 0);

      $display("[TB] reset while entry gate is open");
      @(negedge clk);
      gif.entry_req        = 1'b1;
      gif.entry_is_uni     = 1'b1;
      uni_is_vacated_space = 1'b1;
      @(negedge clk);
      gif.entry_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset          = 1'b0;
      gif.entry_pass = 1'b1;
      @(negedge clk);
      gif.entry_pass = 1'b0;

      $display("[TB] randomized traffic on both gates");
      fork
         begin
            repeat (25) applyStimulus(1'b0, 1'($urandom),
                                      ($urandom_range(0, 3) == 0) ? 0 : 1,
                                      $urandom_range(1, T_OPEN + 3), $urandom_range(0, 3));
         end
         begin
            repeat (25) applyStimulus(1'b1, 1'($urandom),
                                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1023),
                                      $urandom_range(1, T_OPEN + 3), $urandom_range(0, 3));
         end
      join

      repeat (260) @(negedge clk);
      done = 1'b1;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
Drives the event side of parking_management. It takes raw gate-sensor and badge inputs and the vacancy/occupancy status fed back from the counter block. It runs an entry gate FSM and an exit gate FSM, and emits the one-cycle car_entered/car_exited pulses with their class bits. It also generates the current_hour value that parking_management consumes.

Parameters:
CYCLES_PER_HOUR, 10, clk cycles per simulated hour (min 2)
START_HOUR, 0, hour value loaded at reset (0..23)
OPEN_TIMEOUT, 8, max cycles a gate stays open waiting for the pass sensor (min 1)
CLOSE_HOLD, 2, cycles a gate stays closed/busy after closing (min 2, so feedback counters settle)
CNT_W, 10, width of occupancy count inputs

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
entry_req  in  1  car at entry barrier; sampled only in IDLE
entry_is_uni  in  1  badge class at entry (1 = university)
entry_pass  in  1  entry loop sensor: car has driven through
exit_req  in  1  car at exit barrier; sampled only in IDLE
exit_is_uni  in  1  badge class at exit
exit_pass  in  1  exit loop sensor
uni_is_vacated_space  in  1  from parking_management
is_vacated_space  in  1  from parking_management
uni_parked_car  in  CNT_W  from parking_management
parked_car  in  CNT_W  from parking_management
current_hour  out  8  to parking_management
car_entered  out  1  one-cycle pulse
is_uni_car_entered  out  1  class, valid only with car_entered, else 0
car_exited  out  1  one-cycle pulse
is_uni_car_exited  out  1  class, valid only with car_exited, else 0
entry_gate_open  out  1  barrier actuator
exit_gate_open  out  1  barrier actuator
entry_denied  out  1  one-cycle pulse: no space for class
exit_denied  out  1  one-cycle pulse: no parked car of class
entry_timeout  out  1  one-cycle pulse: gate opened, no car passed
exit_timeout  out  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0 except current_hour = START_HOUR. Both FSMs go to IDLE. Timers and the cycle counter clear. Reset mid-operation closes gates immediately and drops any pending event.
- Hour generator: a cycle counter runs 0..CYCLES_PER_HOUR-1. On wrap, current_hour increments; 23 wraps to 0.
- Gate FSM (identical for entry/exit), states IDLE, OPEN, DENY, CLOSE, all outputs registered:
  - IDLE: if req=1 at edge N, latch is_uni. If permit=1, go to OPEN at N+1 with gate_open=1; otherwise go to DENY at N+1.
  - DENY: denied=1 for exactly one cycle, then IDLE.
  - OPEN: a timer counts cycles in OPEN. If pass=1 at an edge, the next cycle has gate_open=0, event pulse=1, class bit = latched class, and the state becomes CLOSE. If the timer reaches OPEN_TIMEOUT with no pass, the next cycle has gate_open=0, timeout=1 (one cycle), and the state becomes CLOSE. If pass and timeout coincide, pass wins and no timeout pulse is issued.
  - CLOSE: hold for CLOSE_HOLD cycles, then IDLE.
  - req is ignored outside IDLE; it is not queued. pass is ignored outside OPEN.
- Entry permit: entry_is_uni ? uni_is_vacated_space : is_vacated_space.
- Exit permit: exit_is_uni ? (uni_parked_car != 0) : (parked_car != 0).
- Entry and exit FSMs are fully independent. car_entered and car_exited may pulse in the same cycle.
- Event pulses are never longer than one cycle. At most one event per gate per FSM pass.

Decomposition:
- Package parking_pkg holds: gate state enum {IDLE, OPEN, DENY, CLOSE}, HOURS_PER_DAY = 24, HOUR_W = 8, default CNT_W = 10.
- Sub-module parking_gate_fsm (params OPEN_TIMEOUT, CLOSE_HOLD; ports clk, reset, req, is_uni, permit, pass, gate_open, event, event_is_uni, denied, timeout) is instantiated twice.
- Top level holds the permit muxes and the hour generator.

Test Plan:
- Reset with CYCLES_PER_HOUR=10, START_HOUR=0 -> all outputs 0, current_hour=0. After 10 cycles current_hour=1. After 240 cycles it wraps back to 0.
- entry_req=1, entry_is_uni=1, uni_is_vacated_space=1; entry_pass 3 cycles after open -> entry_gate_open high 3 cycles, then car_entered=1 and is_uni_car_entered=1 for 1 cycle, then 2 busy cycles before the next request is accepted.
- entry_req=1, entry_is_uni=0, is_vacated_space=0 -> entry_denied=1 for exactly one cycle, gate never opens, no car_entered.
- exit_req=1, exit_is_uni=0, parked_car=3; no exit_pass -> exit_gate_open high 8 cycles, then exit_timeout=1 for 1 cycle, car_exited stays 0. With parked_car=0 -> exit_denied pulse.
- Entry and exit both requested and passed on the same cycles -> car_entered and car_exited pulse in the same cycle with correct class bits.
- entry_pass arrives on the timeout cycle -> car_entered pulses, no entry_timeout. Separately, reset asserted while OPEN -> gate_open=0 next cycle and no event emitted.
